key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter N, default 6, giving the number of independent key channels.
REQ-002 The block SHALL have parameter TIMEOUT, default 32'h05, giving the debounce stability window in clk cycles; legal range 1 to 2^32-1.
REQ-003 The block SHALL have parameter LONG_TIMEOUT, default 32'h20, giving the long-press hold threshold in clk cycles; legal range 1 to 2^32-1.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 key_in  input  N  raw, asynchronous key levels; 1 = pressed.
REQ-007 key_state  output  N  debounced key level, registered.
REQ-008 key_press  output  N  one-cycle pulse on each debounced press.
REQ-009 key_release  output  N  one-cycle pulse on each debounced release.
REQ-010 key_long  output  N  one-cycle pulse when a held key reaches LONG_TIMEOUT; the port always exists.

Function
REQ-011 Each key_in bit SHALL pass through a 2-flop synchronizer; the second flop output is key_sync.
REQ-012 Each channel SHALL run an independent 4-state FSM (UP, DEB_DN, DOWN, DEB_UP) with a 32-bit counter.
REQ-013 Transitions out of UP:
- key_sync=1: go to DEB_DN, counter=0.
- otherwise: stay in UP.
REQ-014 Transitions in DEB_DN:
- key_sync=0: return to UP with no pulse.
- key_sync=1 and counter==TIMEOUT-1: go to DOWN, set key_state=1, assert key_press for exactly one cycle.
- key_sync=1 otherwise: counter+1.
REQ-015 Transitions out of DOWN:
- key_sync=0: go to DEB_UP, counter=0.
- otherwise: stay in DOWN.
REQ-016 Transitions in DEB_UP:
- key_sync=1: return to DOWN with no pulse.
- key_sync=0 and counter==TIMEOUT-1: go to UP, set key_state=0, assert key_release for exactly one cycle.
- key_sync=0 otherwise: counter+1.
REQ-017 Press latency: for a clean step on key_in, key_state and key_press SHALL go high after the (TIMEOUT+3)th rising edge that samples key_in=1. Release latency is symmetric.
REQ-018 A glitch shorter than TIMEOUT synchronized cycles SHALL produce no change in key_state and no pulse.
REQ-019 Channels SHALL be fully independent; press, release and long pulses on several channels in the same cycle are legal.
REQ-020 key_press and key_release for one channel SHALL never be high in the same cycle. Each debounced transition SHALL produce exactly one pulse.

Reset
REQ-021 reset=0 SHALL asynchronously clear synchronizers, FSMs (to UP), counters, key_state, key_press, key_release and key_long to 0.
REQ-022 Reset asserted mid-debounce SHALL abort the operation with no pulse.
REQ-023 A key held across reset release SHALL produce key_press after the full REQ-017 latency.

Configuration
REQ-024 With macro KEY_DEBOUNCE_LONG_PRESS_EN defined:
- Each channel SHALL have a hold counter that clears on entry to DOWN and counts each cycle in DOWN and DEB_UP.
- The hold counter SHALL saturate at LONG_TIMEOUT.
- key_long SHALL pulse once in the cycle the hold counter reaches LONG_TIMEOUT.
- There SHALL be no repeat pulse until a debounced release and a new press occur.
REQ-025 Without KEY_DEBOUNCE_LONG_PRESS_EN, key_long SHALL be constant 0, no hold-counter logic SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-026 Reset check: TIMEOUT=5; assert reset=0 mid-run -> all outputs 0 within the same cycle, asynchronously.
REQ-027 Clean press: key_in[0] steps 0->1 and holds -> key_state[0]=1 and a single key_press[0] pulse after the 8th sampling edge; all other bits stay 0.
REQ-028 Bounce rejection: key_in[2] high for 4 cycles, low for 1, then high steadily -> no pulse during the bounce; key_press[2] fires 8 edges after the final rise.
REQ-029 Simultaneous events: key_in[1] and key_in[5] rise on the same edge -> both key_press bits pulse in the same cycle. Then key_in[1] falls -> key_release[1] pulses after 8 edges, and key_state[5] stays 1.
REQ-030 Long press (macro defined, LONG_TIMEOUT=32'h20): hold key_in[3] -> exactly one key_long[3] pulse 32 cycles after key_press[3], with no further pulse while held. With the macro undefined, key_long stays 0.
REQ-031 Reset mid-operation: key_in[4] held and reset pulsed while in DEB_DN -> no pulse during reset; key_press[4] fires 8 edges after reset release.

Source files
------------

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Multi-channel key debouncer. Each raw key level is brought into the clk
//   domain through a two-flop synchronizer. A per-channel four-state FSM then
//   accepts a level change only after it has been stable for TIMEOUT cycles.
//
// Optional feature (compile-time macro):
//   KEY_DEBOUNCE_LONG_PRESS_EN - when defined, each channel also gets a hold
//   counter. key_long pulses once when a key has been held for LONG_TIMEOUT
//   cycles after its debounced press. When undefined, key_long is tied to 0
//   and no hold logic exists.
//
// Parameters:
//   N            number of independent key channels
//   TIMEOUT      debounce stability window in clk cycles (1 .. 2^32-1)
//   LONG_TIMEOUT long-press hold threshold in clk cycles (1 .. 2^32-1)
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   key_in       raw asynchronous key levels, 1 = pressed
//   key_state    debounced key level (registered)
//   key_press    one-cycle pulse per debounced press
//   key_release  one-cycle pulse per debounced release
//   key_long     one-cycle pulse when a held key reaches LONG_TIMEOUT
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int          N            = 6,
  parameter logic [31:0] TIMEOUT      = 32'h05,
  parameter logic [31:0] LONG_TIMEOUT = 32'h20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] key_in,
  output logic [N-1:0] key_state,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_long
);

  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT - 32'd1;

  typedef enum logic [1:0] {UP, DEB_DN, DOWN, DEB_UP} state_t;

  // A zero window would make the counter compare wrap to 2^32-1.
  if (TIMEOUT == 32'd0 || LONG_TIMEOUT == 32'd0) begin : g_bad_param
    $error("key_debounce: TIMEOUT and LONG_TIMEOUT must be at least 1");
  end

  logic [N-1:0] sync1_reg;
  logic [N-1:0] sync2_reg;
  logic [N-1:0] key_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= key_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign key_sync = sync2_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic        level_reg, level_next;
    logic        press_reg, press_next;
    logic        release_reg, release_next;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_reg   <= UP;
        cnt_reg     <= '0;
        level_reg   <= 1'b0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
      end else begin
        state_reg   <= state_next;
        cnt_reg     <= cnt_next;
        level_reg   <= level_next;
        press_reg   <= press_next;
        release_reg <= release_next;
      end
    end

    always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      level_next   = level_reg;
      press_next   = 1'b0;
      release_next = 1'b0;
      case (state_reg)
        UP: begin
          if (key_sync[gi]) begin
            state_next = DEB_DN;
            cnt_next   = '0;
          end
        end
        DEB_DN: begin
          if (!key_sync[gi]) begin
            state_next = UP;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_next = DOWN;
            level_next = 1'b1;
            press_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end
        DOWN: begin
          if (!key_sync[gi]) begin
            state_next = DEB_UP;
            cnt_next   = '0;
          end
        end
        DEB_UP: begin
          if (key_sync[gi]) begin
            state_next = DOWN;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_next   = UP;
            level_next   = 1'b0;
            release_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end
        default: state_next = UP;
      endcase
    end

    assign key_state[gi]   = level_reg;
    assign key_press[gi]   = press_reg;
    assign key_release[gi] = release_reg;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam logic [31:0] LONG_LAST = LONG_TIMEOUT - 32'd1;

    logic [31:0] hold_reg, hold_next;
    logic        long_reg, long_next;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        hold_reg <= '0;
        long_reg <= 1'b0;
      end else begin
        hold_reg <= hold_next;
        long_reg <= long_next;
      end
    end

    // The hold count restarts only on a debounced press. A release bounce
    // (DEB_UP back to DOWN) keeps the count, so a saturated counter cannot
    // produce a second long pulse without a real release and new press.
    always_comb begin
      hold_next = hold_reg;
      long_next = 1'b0;
      if (press_next) begin
        hold_next = '0;
      end else if ((state_reg == DOWN || state_reg == DEB_UP) &&
                   hold_reg != LONG_TIMEOUT) begin
        hold_next = hold_reg + 32'd1;
        long_next = (hold_reg == LONG_LAST);
      end
    end

    assign key_long[gi] = long_reg;
`else
    assign key_long[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Directed self-checking bench for key_debounce with N=6, TIMEOUT=5,
//   LONG_TIMEOUT=32. Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point, so edge counts below are the
//   sampling edges after each input change.
// -----------------------------------------------------------------------------
module tb_key_debounce;
  localparam int N = 6;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic [N-1:0] key_in = '0;
  logic [N-1:0] key_state, key_press, key_release, key_long;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .N(N),
    .TIMEOUT(32'h05),
    .LONG_TIMEOUT(32'h20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_in(key_in),
    .key_state(key_state),
    .key_press(key_press),
    .key_release(key_release),
    .key_long(key_long)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges after an input change. Before edge n nothing pulses and the
  // state is st0; at edge n the state becomes st1 with the given pulses; one
  // edge later the pulses have dropped again.
  task automatic expect_edges(input string tag, input int n,
                              input logic [N-1:0] st0, input logic [N-1:0] st1,
                              input logic [N-1:0] pr, input logic [N-1:0] rl);
    for (int e = 1; e <= n; e++) begin
      tick();
      if (e < n) begin
        check({tag, "_state_wait"}, 32'(key_state), 32'(st0));
        check({tag, "_press_wait"}, 32'(key_press), 32'd0);
        check({tag, "_rel_wait"}, 32'(key_release), 32'd0);
      end else begin
        check({tag, "_state"}, 32'(key_state), 32'(st1));
        check({tag, "_press"}, 32'(key_press), 32'(pr));
        check({tag, "_rel"}, 32'(key_release), 32'(rl));
      end
      check({tag, "_long"}, 32'(key_long), 32'd0);
    end
    tick();
    check({tag, "_state_after"}, 32'(key_state), 32'(st1));
    check({tag, "_press_after"}, 32'(key_press), 32'd0);
    check({tag, "_rel_after"}, 32'(key_release), 32'd0);
    check({tag, "_long_after"}, 32'(key_long), 32'd0);
    $display("txn %s: key_in=%b key_state=%b checks=%0d", tag, key_in, key_state, checks);
  endtask

  initial begin
    // Power-on reset
    #12;
    check("por_state", 32'(key_state), 32'd0);
    check("por_press", 32'(key_press), 32'd0);
    check("por_rel", 32'(key_release), 32'd0);
    check("por_long", 32'(key_long), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();

    // Clean press and release on key 0
    key_in = 6'b000001;
    expect_edges("press0", 8, 6'b000000, 6'b000001, 6'b000001, 6'b000000);
    key_in = 6'b000000;
    expect_edges("release0", 8, 6'b000001, 6'b000000, 6'b000000, 6'b000001);

    // Bounce on key 2: high 4, low 1, then steady high
    key_in = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bounce_hi_press", 32'(key_press), 32'd0);
      check("bounce_hi_state", 32'(key_state), 32'd0);
    end
    key_in = 6'b000000;
    tick();
    check("bounce_lo_press", 32'(key_press), 32'd0);
    check("bounce_lo_state", 32'(key_state), 32'd0);
    key_in = 6'b000100;
    expect_edges("bounce2", 8, 6'b000000, 6'b000100, 6'b000100, 6'b000000);

    // Keys 1 and 5 together, then key 1 alone released
    key_in = 6'b100110;
    expect_edges("simul15", 8, 6'b000100, 6'b100110, 6'b100010, 6'b000000);
    key_in = 6'b100100;
    expect_edges("release1", 8, 6'b100110, 6'b100100, 6'b000000, 6'b000010);

    // Key 4 enters DEB_DN, then reset is pulsed mid-cycle
    key_in = 6'b110100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("deb4_press", 32'(key_press), 32'd0);
      check("deb4_state", 32'(key_state), 32'(6'b100100));
    end
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_state", 32'(key_state), 32'd0);
    check("async_rst_press", 32'(key_press), 32'd0);
    check("async_rst_rel", 32'(key_release), 32'd0);
    check("async_rst_long", 32'(key_long), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("in_rst_state", 32'(key_state), 32'd0);
      check("in_rst_press", 32'(key_press), 32'd0);
    end
    reset = 1'b1;
    expect_edges("rst_release", 8, 6'b000000, 6'b110100, 6'b110100, 6'b000000);
    key_in = 6'b000000;
    expect_edges("release_all", 8, 6'b110100, 6'b000000, 6'b000000, 6'b110100);

    // Long press on key 3; press is at edge 0, expect_edges consumed edge 1
    key_in = 6'b001000;
    expect_edges("press3", 8, 6'b000000, 6'b001000, 6'b001000, 6'b000000);
    for (int j = 2; j <= 45; j++) begin
      logic [N-1:0] exp_long;
      tick();
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
      exp_long = (j == 32) ? 6'b001000 : 6'b000000;
`else
      exp_long = 6'b000000;
`endif
      check("long3", 32'(key_long), 32'(exp_long));
      check("long3_state", 32'(key_state), 32'(6'b001000));
    end
    $display("txn long3: key_in=%b key_state=%b checks=%0d", key_in, key_state, checks);
    key_in = 6'b000000;
    expect_edges("release3", 8, 6'b001000, 6'b000000, 6'b000000, 6'b001000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
